// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared state type, segment indices and hex font for seven-segment display blocks
package seven_seg_pkg;
  typedef enum logic {st_blank, st_active} state_t;
  localparam int seg_a = 0;
  localparam int seg_b = 1;
  localparam int seg_c = 2;
  localparam int seg_d = 3;
  localparam int seg_e = 4;
  localparam int seg_f = 5;
  localparam int seg_g = 6;
  localparam int seg_h = 7;
  localparam logic [15:0][6:0] hex_font_rom = {
    7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
    7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };
endpackage

// File: rtl/seven_seg_hex_font.sv
// seven_seg_hex_font: combinational nibble to gfedcba segment pattern
module seven_seg_hex_font (
  input  logic [3:0] nibble,
  output logic [6:0] gfedcba
);
  import seven_seg_pkg::*;
  assign gfedcba = hex_font_rom[nibble];
endmodule

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: frame-latched multiplexed digit scan with blanking gaps
module seven_segment_scan_controller #(
  parameter int w_digit      = 8,
  parameter int w_seg        = 8,
  parameter int scan_cycles  = 1000,
  parameter int blank_cycles = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic [w_digit-1:0]     enable_mask,
  input  logic                   lz_suppress,
  output logic [w_seg-1:0]       hgfedcba,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_done
);
  import seven_seg_pkg::*;
  localparam int cmax = scan_cycles > blank_cycles ? scan_cycles : blank_cycles;
  localparam int cw = $clog2(cmax + 1);
  localparam int iw = $clog2(w_digit);
  localparam state_t st_init = blank_cycles == 0 ? st_active : st_blank;
  state_t state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [iw-1:0] idx_q, idx_d;
  logic first_q;
  logic [4*w_digit-1:0] num_q, num_d;
  logic [w_digit-1:0] dots_q, dots_d, en_q, en_d, lz_q, lz_d, lz_m;
  logic [w_digit-1:0] digit_q, digit_d;
  logic [w_seg-1:0] hgfedcba_q, hgfedcba_d;
  logic frame_done_q, frame_done_d;
  logic blank_end, act_end, load, zeros, on;
  logic [6:0] font;
  logic [7:0] seg;
  seven_seg_hex_font u_font (.nibble(num_d[4*idx_d +: 4]), .gfedcba(font));
  always_comb begin
    blank_end = state_q == st_blank && cnt_q == cw'(blank_cycles - 1);
    act_end = state_q == st_active && cnt_q == cw'(scan_cycles - 1);
    state_d = blank_end ? st_active : act_end ? st_init : state_q;
    cnt_d = (blank_end || act_end) ? '0 : cnt_q + 1'b1;
    idx_d = act_end ? (idx_q == iw'(w_digit - 1) ? '0 : idx_q + 1'b1) : idx_q;
    load = blank_cycles == 0 ? (first_q || (act_end && idx_d == '0))
                             : (state_q == st_blank && idx_q == '0 && cnt_q == '0);
    num_d = load ? number : num_q;
    dots_d = load ? dots : dots_q;
    en_d = load ? enable_mask : en_q;
    zeros = 1'b1;
    lz_m = '0;
    for (int i = w_digit - 1; i > 0; i--) begin
      zeros = zeros && num_d[4*i +: 4] == 4'h0;
      lz_m[i] = lz_suppress && zeros;
    end
    lz_d = load ? lz_m : lz_q;
  end
  always_comb begin
    seg = {dots_d[idx_d], lz_d[idx_d] ? 7'h00 : font};
    on = state_d == st_active && en_d[idx_d] && seg != 8'h00;
    hgfedcba_d = on ? w_seg'(seg) : '0;
    digit_d = on ? (w_digit'(1) << idx_d) : '0;
    frame_done_d = state_d == st_active && idx_d == iw'(w_digit - 1) && cnt_d == cw'(scan_cycles - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= st_init;
      cnt_q        <= '0;
      idx_q        <= '0;
      first_q      <= 1'b1;
      num_q        <= '0;
      dots_q       <= '0;
      en_q         <= '0;
      lz_q         <= '0;
      hgfedcba_q   <= '0;
      digit_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      first_q      <= 1'b0;
      num_q        <= num_d;
      dots_q       <= dots_d;
      en_q         <= en_d;
      lz_q         <= lz_d;
      hgfedcba_q   <= hgfedcba_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign hgfedcba = hgfedcba_q;
  assign digit = digit_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb_seven_segment_scan_controller: scoreboard bench for blanked and unblanked scan controllers
module tb_seven_segment_scan_controller;
  logic clk = 1'b0, rst = 1'b1, lz_suppress = 1'b0;
  logic [15:0] number = 16'h0;
  logic [3:0] dots = 4'h0, enable_mask = 4'h0;
  logic [7:0] hgfedcba, hgfedcba0;
  logic [3:0] digit, digit0;
  logic frame_done, frame_done0;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [7:0] h; logic [3:0] d; logic f;} exp_t;
  exp_t exp_q[$];
  logic [6:0] font_t [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                              7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  always #5 clk = ~clk;
  seven_segment_scan_controller #(.w_digit(4), .w_seg(8), .scan_cycles(3), .blank_cycles(1)) dut (
    .clk(clk), .rst(rst), .number(number), .dots(dots), .enable_mask(enable_mask),
    .lz_suppress(lz_suppress), .hgfedcba(hgfedcba), .digit(digit), .frame_done(frame_done));
  seven_segment_scan_controller #(.w_digit(4), .w_seg(8), .scan_cycles(3), .blank_cycles(0)) dut_b0 (
    .clk(clk), .rst(rst), .number(number), .dots(dots), .enable_mask(enable_mask),
    .lz_suppress(lz_suppress), .hgfedcba(hgfedcba0), .digit(digit0), .frame_done(frame_done0));

  task automatic push_frame(input logic [15:0] num, input logic [3:0] dt, input logic [3:0] en,
                            input logic lz, input int b);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] seg;
      logic lit;
      repeat (b) exp_q.push_back('0);
      seg = {dt[i], (lz && i > 0 && (num >> (4 * i)) == 16'h0) ? 7'h00 : font_t[num[4*i +: 4]]};
      lit = en[i] && seg != 8'h00;
      for (int k = 0; k < 3; k++)
        exp_q.push_back({lit ? seg : 8'h00, lit ? (4'b0001 << i) : 4'b0000, i == 3 && k == 2});
    end
  endtask

  task automatic set_in(input logic [15:0] num, input logic [3:0] dt, input logic [3:0] en, input logic lz);
    number = num;
    dots = dt;
    enable_mask = en;
    lz_suppress = lz;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({hgfedcba, digit, frame_done} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_b1: got h=%h d=%b fd=%b want all 0", hgfedcba, digit, frame_done);
    end
    vectors++;
    if ({hgfedcba0, digit0, frame_done0} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_b0: got h=%h d=%b fd=%b want all 0", hgfedcba0, digit0, frame_done0);
    end
  endtask

  task automatic test_basic;
    set_in(16'h12AF, 4'h0, 4'hf, 1'b0);
    push_frame(16'h12AF, 4'h0, 4'hf, 1'b0, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; exp_q.size() > 0; c++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({hgfedcba, digit, frame_done} !== e) begin
        miscompares++;
        $display("FAIL basic cyc %0d: got h=%h d=%b fd=%b want h=%h d=%b fd=%b", c, hgfedcba, digit, frame_done, e.h, e.d, e.f);
      end
    end
  endtask

  task automatic test_lz;
    set_in(16'h0040, 4'b1000, 4'hf, 1'b1);
    push_frame(16'h0040, 4'b1000, 4'hf, 1'b1, 1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({hgfedcba, digit, frame_done} !== e) begin
        miscompares++;
        $display("FAIL lz cyc %0d: got h=%h d=%b fd=%b want h=%h d=%b fd=%b", c, hgfedcba, digit, frame_done, e.h, e.d, e.f);
      end
    end
  endtask

  task automatic test_zero;
    set_in(16'h0000, 4'h0, 4'hf, 1'b1);
    push_frame(16'h0000, 4'h0, 4'hf, 1'b1, 1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({hgfedcba, digit, frame_done} !== e) begin
        miscompares++;
        $display("FAIL zero cyc %0d: got h=%h d=%b fd=%b want h=%h d=%b fd=%b", c, hgfedcba, digit, frame_done, e.h, e.d, e.f);
      end
    end
  endtask

  task automatic test_mask;
    set_in(16'h12AF, 4'h0, 4'b0101, 1'b0);
    push_frame(16'h12AF, 4'h0, 4'b0101, 1'b0, 1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({hgfedcba, digit, frame_done} !== e) begin
        miscompares++;
        $display("FAIL mask cyc %0d: got h=%h d=%b fd=%b want h=%h d=%b fd=%b", c, hgfedcba, digit, frame_done, e.h, e.d, e.f);
      end
    end
  endtask

  task automatic test_midframe;
    set_in(16'h1234, 4'h0, 4'hf, 1'b0);
    push_frame(16'h1234, 4'h0, 4'hf, 1'b0, 1);
    push_frame(16'h5678, 4'h0, 4'hf, 1'b0, 1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({hgfedcba, digit, frame_done} !== e) begin
        miscompares++;
        $display("FAIL midframe cyc %0d: got h=%h d=%b fd=%b want h=%h d=%b fd=%b", c, hgfedcba, digit, frame_done, e.h, e.d, e.f);
      end
      if (c == 6) number = 16'h5678;
    end
  endtask

  task automatic test_reset_mid;
    set_in(16'hBEEF, 4'b0100, 4'hf, 1'b0);
    push_frame(16'hBEEF, 4'b0100, 4'hf, 1'b0, 1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({hgfedcba, digit, frame_done} !== e) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d: got h=%h d=%b fd=%b want h=%h d=%b fd=%b", c, hgfedcba, digit, frame_done, e.h, e.d, e.f);
      end
      if (c == 9) begin
        rst = 1'b1;
        exp_q.delete();
        push_frame(16'hBEEF, 4'b0100, 4'hf, 1'b0, 1);
      end
      if (c == 10) rst = 1'b0;
    end
  endtask

  task automatic test_b0;
    set_in(16'h3C5D, 4'b0010, 4'hf, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    push_frame(16'h3C5D, 4'b0010, 4'hf, 1'b0, 0);
    for (int c = 12; exp_q.size() > 0; c++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({hgfedcba0, digit0, frame_done0} !== e) begin
        miscompares++;
        $display("FAIL b0 cyc %0d: got h=%h d=%b fd=%b want h=%h d=%b fd=%b", c, hgfedcba0, digit0, frame_done0, e.h, e.d, e.f);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_lz;
    test_zero;
    test_mask;
    test_midframe;
    test_reset_mid;
    test_b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
